// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor helper used by the tick generator.
// The default divisor is computed at elaboration time from the clock and baud parameters.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int FRAC_BITS_DEF  = 8;
  localparam int MIN_DIV        = 2 << FRAC_BITS_DEF;

  // Rounded clocks-per-sample-tick in unsigned fixed point with frac_bits fraction bits.
  function automatic longint unsigned calc_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     frac_bits = FRAC_BITS_DEF
  );
    longint unsigned den;
    den = baud * os;
    return ((clk_hz << frac_bits) + den / 2) / den;
  endfunction

endpackage

// File: rtl/frac_accum.sv
// Fractional-N phase accumulator: adds ONE per enabled cycle and wraps by div,
// flagging a tick on each wrap.
module frac_accum #(
  parameter int DIV_W     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic [DIV_W+FRAC_BITS-1:0] div,
  output logic                       tick
);

  localparam int ACC_W = DIV_W + FRAC_BITS + 1;
  localparam logic [ACC_W-1:0] ONE = ACC_W'(1) << FRAC_BITS;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] div_ext;
  logic [ACC_W-1:0] acc_next;
  logic             wrap;

  // acc stays below div, so acc+ONE always fits in the extra headroom bit.
  assign sum     = acc + ONE;
  assign div_ext = {1'b0, div};
  assign wrap    = (sum >= div_ext);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    acc_next = acc;
    tick     = 1'b0;
    if (clr) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = wrap ? (sum - div_ext) : sum;
      tick     = wrap;
    end
  end

  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc_next;
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Oversampling baud tick generator: divisor register, sample index and
// registered one-cycle s_tick / bit_tick / mid_tick enables.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = 16,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          restart,
  input  logic                          div_wr,
  input  logic [DIV_W+FRAC_BITS-1:0]    div_in,
  output logic                          s_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_idx,
  output logic                          div_err
);

  localparam int D_W   = DIV_W + FRAC_BITS;
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam logic [D_W-1:0] DEFAULT_DIV =
    D_W'(calc_div(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE), FRAC_BITS));
  localparam logic [D_W-1:0]   MIN_D    = D_W'(2) << FRAC_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(OVERSAMPLE / 2 - 1);

  logic [D_W-1:0] div_q;
  logic           div_ok;
  logic           clr;
  logic           tick;

  // The 2.0 floor keeps s_tick pulses at least two cycles apart.
  assign div_ok = div_wr && (div_in >= MIN_D);
  assign clr    = restart || div_ok;

  frac_accum #(
    .DIV_W     (DIV_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_accum (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .div   (div_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= DEFAULT_DIV;
      div_err    <= 1'b0;
      sample_idx <= '0;
      s_tick     <= 1'b0;
      bit_tick   <= 1'b0;
      mid_tick   <= 1'b0;
    end else begin
      s_tick   <= tick;
      bit_tick <= tick && (sample_idx == LAST_IDX);
      mid_tick <= tick && (sample_idx == MID_IDX);

      if (restart)   sample_idx <= '0;
      else if (tick) sample_idx <= sample_idx + IDX_W'(1);

      // A rejected write leaves the divisor alone; only the sticky flag records it.
      if (div_wr) begin
        div_err <= !div_ok;
        if (div_ok) div_q <= div_in;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: default, integer and fractional divisors,
// divisor rejection, restart, freeze and asynchronous reset.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        restart;
  logic        div_wr;
  logic [23:0] div_in;
  logic        s_tick;
  logic        bit_tick;
  logic        mid_tick;
  logic [3:0]  sample_idx;
  logic        div_err;

  int errors = 0;
  int checks = 0;
  int s_q[$];
  int b_q[$];
  int m_q[$];
  int stray;

  baud_tick_gen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .restart    (restart),
    .div_wr     (div_wr),
    .div_in     (div_in),
    .s_tick     (s_tick),
    .bit_tick   (bit_tick),
    .mid_tick   (mid_tick),
    .sample_idx (sample_idx),
    .div_err    (div_err)
  );

  always #5 clk = ~clk;

  // Collect edge numbers (1-based, relative to the call) at which each pulse is seen.
  task automatic run(input int n);
    s_q.delete(); b_q.delete(); m_q.delete(); stray = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (s_tick)   s_q.push_back(c);
      if (bit_tick) b_q.push_back(c);
      if (mid_tick) m_q.push_back(c);
      if ((bit_tick || mid_tick) && !s_tick) stray++;
    end
  endtask

  task automatic write_div(input logic [23:0] v, input logic rs);
    div_in = v; div_wr = 1'b1; restart = rs;
    @(negedge clk);
    div_wr = 1'b0; restart = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({s_tick, bit_tick, mid_tick} !== 3'b000) begin errors++; $display("FAIL reset_ticks got=%b want=000", {s_tick, bit_tick, mid_tick}); end
    checks++; if (sample_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", sample_idx); end
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL reset_div_err got=%b want=0", div_err); end
    checks++; if (dut.div_q !== 24'd166667) begin errors++; $display("FAIL reset_div_q got=%0d want=166667", dut.div_q); end
  endtask

  task automatic test_default();
    int t[$];
    int bad = 0;
    int mid_at = 0;
    reset = 1'b0;
    for (int c = 1; c <= 12000 && t.size() < 17; c++) begin
      @(negedge clk);
      if (s_tick) t.push_back(c);
      if (mid_tick && mid_at == 0) mid_at = c;
    end
    checks++;
    if (t.size() != 17) begin
      errors++; $display("FAIL default_timeout ticks=%0d want=17", t.size());
    end else begin
      for (int i = 1; i < 17; i++) if (t[i] - t[i-1] != 651 && t[i] - t[i-1] != 652) bad++;
      checks++; if (t[0] != 652) begin errors++; $display("FAIL default_first got=%0d want=652", t[0]); end
      checks++; if (bad != 0) begin errors++; $display("FAIL default_intervals bad=%0d want=0", bad); end
      checks++; if (t[16] - t[0] != 10416) begin errors++; $display("FAIL default_span got=%0d want=10416", t[16] - t[0]); end
      checks++; if (mid_at != 5209) begin errors++; $display("FAIL default_mid got=%0d want=5209", mid_at); end
    end
  endtask

  task automatic test_integer();
    int bad = 0;
    write_div(24'd1024, 1'b1);
    run(128);
    for (int i = 1; i < s_q.size(); i++) if (s_q[i] - s_q[i-1] != 4) bad++;
    checks++; if (s_q.size() != 32) begin errors++; $display("FAIL int_count got=%0d want=32", s_q.size()); end
    checks++; if (s_q.size() == 0 || s_q[0] != 4) begin errors++; $display("FAIL int_first got=%0d want=4", s_q.size() ? s_q[0] : -1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL int_period bad=%0d want=0", bad); end
    checks++; if (b_q.size() != 2 || b_q[0] != 64 || b_q[1] != 128) begin errors++; $display("FAIL int_bit_tick got=%p want=64,128", b_q); end
    checks++; if (m_q.size() != 2 || m_q[0] != 32 || m_q[1] != 96) begin errors++; $display("FAIL int_mid_tick got=%p want=32,96", m_q); end
    checks++; if (stray != 0) begin errors++; $display("FAIL int_coincide stray=%0d want=0", stray); end
    checks++; if (sample_idx !== 4'd0) begin errors++; $display("FAIL int_idx got=%0d want=0", sample_idx); end
  endtask

  task automatic test_fractional();
    int bad = 0;
    write_div(24'd640, 1'b1);
    run(1000);
    for (int i = 1; i < s_q.size(); i++) if (s_q[i] - s_q[i-1] != ((i % 2 == 1) ? 2 : 3)) bad++;
    checks++; if (s_q.size() != 400) begin errors++; $display("FAIL frac_count got=%0d want=400", s_q.size()); end
    checks++; if (s_q.size() == 0 || s_q[0] != 3) begin errors++; $display("FAIL frac_first got=%0d want=3", s_q.size() ? s_q[0] : -1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL frac_alternate bad=%0d want=0", bad); end
  endtask

  task automatic test_invalid();
    int bad = 0;
    write_div(24'd300, 1'b0);
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL inv_300_err got=%b want=1", div_err); end
    run(100);
    for (int i = 1; i < s_q.size(); i++) if (s_q[i] - s_q[i-1] != 2 && s_q[i] - s_q[i-1] != 3) bad++;
    checks++; if (s_q.size() != 40 || bad != 0) begin errors++; $display("FAIL inv_keep_period count=%0d bad=%0d want=40,0", s_q.size(), bad); end
    write_div(24'd511, 1'b0);
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL inv_511_err got=%b want=1", div_err); end
    write_div(24'd512, 1'b0);
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL inv_512_err got=%b want=0", div_err); end
    run(20);
    checks++; if (s_q.size() != 10 || s_q[0] != 2) begin errors++; $display("FAIL inv_512_period got=%p want=2,4,..,20", s_q); end
    write_div(24'd1024, 1'b0);
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL inv_1024_err got=%b want=0", div_err); end
    run(40);
    checks++; if (s_q.size() != 10 || s_q[0] != 4) begin errors++; $display("FAIL inv_1024_period got=%p want=4,8,..,40", s_q); end
  endtask

  task automatic test_restart();
    write_div(24'd1024, 1'b1);
    run(37);
    checks++; if (sample_idx !== 4'd9) begin errors++; $display("FAIL rst_idx_before got=%0d want=9", sample_idx); end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++; if (sample_idx !== 4'd0 || s_tick !== 1'b0) begin errors++; $display("FAIL rst_idx_after idx=%0d s_tick=%b want=0,0", sample_idx, s_tick); end
    run(8);
    checks++; if (s_q.size() != 2 || s_q[0] != 4) begin errors++; $display("FAIL rst_first got=%p want=4,8", s_q); end
  endtask

  task automatic test_freeze();
    write_div(24'd1024, 1'b1);
    run(6);
    en = 1'b0;
    run(10);
    checks++; if (s_q.size() != 0 || b_q.size() != 0 || m_q.size() != 0) begin errors++; $display("FAIL frz_ticks s=%0d b=%0d m=%0d want=0", s_q.size(), b_q.size(), m_q.size()); end
    checks++; if (sample_idx !== 4'd1) begin errors++; $display("FAIL frz_idx got=%0d want=1", sample_idx); end
    checks++; if (dut.u_accum.acc !== 25'd512) begin errors++; $display("FAIL frz_acc got=%0d want=512", dut.u_accum.acc); end
    en = 1'b1;
    run(12);
    checks++; if (s_q.size() != 3 || s_q[0] != 2 || s_q[2] != 10) begin errors++; $display("FAIL frz_resume got=%p want=2,6,10", s_q); end
  endtask

  task automatic test_back_to_back();
    write_div(24'd1024, 1'b1);
    write_div(24'd300, 1'b0);
    run(3);
    checks++; if (s_tick !== 1'b1 || div_err !== 1'b1) begin errors++; $display("FAIL arst_setup s_tick=%b div_err=%b want=1,1", s_tick, div_err); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({s_tick, bit_tick, mid_tick} !== 3'b000 || sample_idx !== 4'd0 || div_err !== 1'b0) begin
      errors++; $display("FAIL arst_outputs ticks=%b idx=%0d err=%b want=000,0,0", {s_tick, bit_tick, mid_tick}, sample_idx, div_err);
    end
    checks++; if (dut.div_q !== 24'd166667) begin errors++; $display("FAIL arst_div_q got=%0d want=166667", dut.div_q); end
    @(negedge clk);
    reset = 1'b0;
    write_div(24'd1024, 1'b1);
    run(3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++; if (s_tick !== 1'b0 || sample_idx !== 4'd0) begin errors++; $display("FAIL arst_pending s_tick=%b idx=%0d want=0,0", s_tick, sample_idx); end
    run(4);
    checks++; if (s_q.size() != 1 || s_q[0] != 4) begin errors++; $display("FAIL arst_realign got=%p want=4", s_q); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; restart = 1'b0; div_wr = 1'b0; div_in = '0;
    test_reset();
    test_default();
    test_integer();
    test_fractional();
    test_invalid();
    test_restart();
    test_freeze();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised fractional-N oversampling tick generator for the UART communication module. It divides the system clock into one-cycle enable pulses at BAUD×OVERSAMPLE: `s_tick` for the receiver sampler, `bit_tick` for the transmitter, and `mid_tick` at bit centre. The divisor can be reprogrammed at run time, and the tick phase can be realigned on a detected start edge. All outputs are clock enables, never clocks.

## Interface
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD, 9600, reset-time baud rate.
- OVERSAMPLE, 16, sample ticks per bit; power of two, 4..64.
- DIV_W, 16, integer bits of divisor.
- FRAC_BITS, 8, fractional bits of divisor.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; low freezes all state.
- restart  in  1  synchronous phase realign (RX start-edge detect).
- div_wr  in  1  load `div_in` this cycle.
- div_in  in  DIV_W+FRAC_BITS  new divisor, unsigned fixed point (clocks per sample tick).
- s_tick  out  1  one-cycle sample enable.
- bit_tick  out  1  one-cycle pulse, once per OVERSAMPLE s_ticks.
- mid_tick  out  1  one-cycle pulse at sample OVERSAMPLE/2−1.
- sample_idx  out  log2(OVERSAMPLE)  current sample index within bit.
- div_err  out  1  sticky: last `div_wr` was rejected.

## Operation
- ONE = 2^FRAC_BITS. DEFAULT_DIV = round(CLK_HZ·ONE/(BAUD·OVERSAMPLE)). For 100 MHz / 9600 / 16 this is 166667 (651.04 clocks).
- State:
  - `div_q`: divisor register; reset value DEFAULT_DIV.
  - `acc`: accumulator, DIV_W+FRAC_BITS+1 bits, unsigned; reset value 0.
  - `sample_idx`: reset value 0.
- Each clk edge with `en`=1:
  - If acc+ONE ≥ div_q: acc ← acc+ONE−div_q, and a tick is issued.
  - Otherwise: acc ← acc+ONE.
  - No overflow is possible given the acc width.
- On a tick:
  - `s_tick` is registered high for the next cycle.
  - `bit_tick` is high in that same cycle iff sample_idx was OVERSAMPLE−1.
  - `mid_tick` is high iff sample_idx was OVERSAMPLE/2−1.
  - sample_idx increments modulo OVERSAMPLE.
- `en`=0: acc and sample_idx hold, all tick outputs are 0. `div_wr` and `restart` are still honoured.
- `restart`=1: acc ← 0, sample_idx ← 0, no tick next cycle, regardless of `en`.
- `div_wr`=1 with div_in ≥ 2·ONE:
  - div_q ← div_in, acc ← 0, sample_idx unchanged.
  - div_err ← 0.
- `div_wr`=1 with div_in < 2·ONE: rejected. div_q is unchanged, div_err ← 1, and the counting step proceeds normally.
- Simultaneous events:
  - `restart` and a valid `div_wr`: both apply (acc 0, idx 0, new divisor).
  - A tick condition coinciding with `restart` or a valid `div_wr` is suppressed.
- Reset at any time: all registers return to their reset values immediately. Outputs are 0 and div_err is 0.

## Timing
- Outputs are registered and fall 1 cycle after their tick edge. Every pulse is exactly 1 cycle wide.
- Integer divisor N·ONE: s_tick period is exactly N cycles. The first s_tick is high in the cycle after the N-th enabled edge following reset release, restart or divisor load.
- Fractional divisor: intervals are ⌊D/ONE⌋ or ⌈D/ONE⌉ cycles. The long-run average is D/ONE, and the cumulative error never exceeds 1 cycle.
- Minimum s_tick spacing is 2 cycles, guaranteed by the 2·ONE divisor floor.
- bit_tick period = OVERSAMPLE × s_tick period. mid_tick leads bit_tick by OVERSAMPLE/2 s_ticks.

## Structure
- Shared package `uart_pkg`:
  - `OVERSAMPLE_DEF`, `FRAC_BITS_DEF`.
  - The `calc_div(clk_hz, baud, os)` constant function.
  - `MIN_DIV` = 2·ONE.
- Sub-module `frac_accum`: accumulator plus compare/subtract. Inputs en, clr, div. Output tick.
- The top level holds div_q, div_err, the sample index counter and the output registers.

## Test plan
- Integer divisor: div_in=1024 (4.0), en=1 → s_tick every 4 cycles; bit_tick every 64 cycles coincident with s_tick; mid_tick at s_tick #8 of each bit.
- Fractional divisor: div_in=640 (2.5) → intervals alternate 3,2; exactly 400 s_ticks in 1000 enabled cycles.
- Default divisor: reset, no writes → 1535 or 1536 s_ticks in 1,000,000 cycles; no interval outside {651,652}.
- Invalid divisor: div_in=300 → div_err=1, period unchanged. A following div_in=1024 → div_err=0, period 4.
- Restart and freeze:
  - restart at sample_idx=9 → idx 0, first s_tick 4 cycles later (div 4.0).
  - en low for 10 cycles → no ticks, acc and idx frozen, period resumes seamlessly.
- Async reset mid-bit: reset asserted between edges → all outputs 0 immediately, div_q returns to 166667, and restart coincident with a pending tick emits no pulse.
